// File: rtl/ram_dma_ci_engine.sv
// ram_dma_ci_engine: custom-instruction scratchpad RAM with a block-move engine.
//
// Port A serves CPU READ/WRITE requests; port B is owned by the copy/fill
// engine. READ and STATUS are answered at once even while the engine runs.
// Other valid commands are parked until the engine is idle, so the two ports
// never write in the same cycle.
//
// Handshake: a request is start=1 with ciN==customId, sampled on a rising
// clock edge. done pulses for exactly one cycle per accepted request, and
// result is non-zero only while done=1. The CPU must not issue a new request
// before it has seen done for the previous one.
//
// Optional feature macro: RAM_DMA_CI_FILL_EN enables opcode 6 (START_FILL)
// and the FILL engine state. Without it, opcode 6 is rejected as invalid.
module ram_dma_ci_engine #(
  parameter logic [7:0] customId = 8'h00,
  parameter int         addrBits = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam int DEPTH = 1 << addrBits;
  localparam logic [addrBits:0] LEN_MAX = {1'b1, {addrBits{1'b0}}};
  localparam logic [addrBits:0] LEN_ONE = {{addrBits{1'b0}}, 1'b1};

  localparam logic [2:0] OP_READ    = 3'd0;
  localparam logic [2:0] OP_WRITE   = 3'd1;
  localparam logic [2:0] OP_SET_SRC = 3'd2;
  localparam logic [2:0] OP_SET_DST = 3'd3;
  localparam logic [2:0] OP_SET_LEN = 3'd4;
  localparam logic [2:0] OP_COPY    = 3'd5;
  localparam logic [2:0] OP_FILL    = 3'd6;
  localparam logic [2:0] OP_STATUS  = 3'd7;

`ifdef RAM_DMA_CI_FILL_EN
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FILL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
`endif

  state_t state, state_nx;

  logic [31:0]         mem [DEPTH];
  logic [addrBits-1:0] src, dst, rp, wp;
  logic [addrBits:0]   len, remaining;
  logic [31:0]         rdata;
`ifdef RAM_DMA_CI_FILL_EN
  logic [31:0]         pattern;
  logic                go_fill;
`endif

  logic                pend_valid;
  logic [2:0]          pend_op;
  logic [addrBits-1:0] pend_addr;
  logic [31:0]         pend_data;

  logic                req, in_bad, busy, use_pend, immediate, hold, exec;
  logic                x_valid, a_we, b_we, go_copy;
  logic [2:0]          in_op, x_op;
  logic [addrBits-1:0] x_addr;
  logic [31:0]         x_data, b_wdata;
  logic [addrBits:0]   len_in, len_sat;

  // Request decode and selection of the command executed this cycle.
  always_comb begin
    req       = start && (ciN == customId);
    in_op     = valueA[12:10];
    in_bad    = (valueA[31:13] != 19'd0) || ((valueA[9:0] >> addrBits) != 10'd0);
`ifndef RAM_DMA_CI_FILL_EN
    if (in_op == OP_FILL) in_bad = 1'b1;
`endif
    busy      = (state != S_IDLE);
    use_pend  = pend_valid && !busy;
    // Invalid commands, READ and STATUS never wait for the engine.
    immediate = req && (in_bad || !busy || in_op == OP_READ || in_op == OP_STATUS);
    hold      = req && !immediate;
    exec      = use_pend || immediate;
    x_op      = use_pend ? pend_op   : in_op;
    x_addr    = use_pend ? pend_addr : valueA[addrBits-1:0];
    x_data    = use_pend ? pend_data : valueB;
    x_valid   = use_pend || (immediate && !in_bad);
    a_we      = x_valid && (x_op == OP_WRITE);
    go_copy   = x_valid && (x_op == OP_COPY) && (len != '0);
`ifdef RAM_DMA_CI_FILL_EN
    go_fill   = x_valid && (x_op == OP_FILL) && (len != '0);
    b_we      = (state == S_WR) || (state == S_FILL);
    b_wdata   = (state == S_WR) ? rdata : pattern;
`else
    b_we      = (state == S_WR);
    b_wdata   = rdata;
`endif
    len_in    = x_data[addrBits:0];
    len_sat   = (len_in > LEN_MAX) ? LEN_MAX : len_in;
  end

  // Engine next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (go_copy) state_nx = S_RD;
`ifdef RAM_DMA_CI_FILL_EN
        else if (go_fill) state_nx = S_FILL;
`endif
      end
      S_RD:   state_nx = S_WR;
      S_WR:   state_nx = (remaining > LEN_ONE) ? S_RD : S_IDLE;
`ifdef RAM_DMA_CI_FILL_EN
      S_FILL: state_nx = (remaining > LEN_ONE) ? S_FILL : S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Engine state register; reset aborts any transfer in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // RAM array: port A write from the CPU, port B read/write from the engine.
  always_ff @(posedge clock) begin
    if (a_we)      mem[x_addr] <= x_data;
    else if (b_we) mem[wp]     <= b_wdata;
    if (state == S_RD) rdata <= mem[rp];
  end

  // Command execution, response, pending slot and engine pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done       <= 1'b0;
      result     <= '0;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      rp         <= '0;
      wp         <= '0;
      remaining  <= '0;
      pend_valid <= 1'b0;
      pend_op    <= '0;
      pend_addr  <= '0;
      pend_data  <= '0;
`ifdef RAM_DMA_CI_FILL_EN
      pattern    <= '0;
`endif
    end else begin
      done   <= exec;
      result <= '0;
      if (x_valid) begin
        case (x_op)
          OP_READ:    result <= mem[x_addr];
          OP_SET_SRC: src <= x_data[addrBits-1:0];
          OP_SET_DST: dst <= x_data[addrBits-1:0];
          OP_SET_LEN: len <= len_sat;
          OP_COPY: begin
            if (len != '0) begin
              remaining <= len;
              rp        <= src;
              wp        <= dst;
            end
          end
`ifdef RAM_DMA_CI_FILL_EN
          OP_FILL: begin
            if (len != '0) begin
              remaining <= len;
              wp        <= dst;
              pattern   <= x_data;
            end
          end
`endif
          OP_STATUS:  result <= {busy, {(30-addrBits){1'b0}}, remaining};
          default: ;
        endcase
      end
      if (hold) begin
        pend_valid <= 1'b1;
        pend_op    <= in_op;
        pend_addr  <= valueA[addrBits-1:0];
        pend_data  <= valueB;
      end else if (use_pend) begin
        pend_valid <= 1'b0;
      end
      if (state == S_WR) begin
        rp        <= rp + 1'b1;
        wp        <= wp + 1'b1;
        remaining <= remaining - 1'b1;
      end
`ifdef RAM_DMA_CI_FILL_EN
      else if (state == S_FILL) begin
        wp        <= wp + 1'b1;
        remaining <= remaining - 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ram_dma_ci_engine.sv
// Self-checking bench for ram_dma_ci_engine (addrBits=9, customId=0x5A).
// Follows RAM_DMA_CI_FILL_EN so it can be built with or without the fill option.
module tb_ram_dma_ci_engine;

  localparam int         AB  = 9;
  localparam int         D   = 1 << AB;
  localparam logic [7:0] CID = 8'h5A;

  logic        clock, reset, start, done;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB, result;

  ram_dma_ci_engine #(.customId(CID), .addrBits(AB)) dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .done(done), .result(result)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int n_pass = 0;
  int n_total = 0;
  bit zero_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Memory image plus the timeline of the current transfer, measured in clock
  // edges: the transfer starts at edge m_e0 and the cycle ending at edge er is
  // busy when m_e0 < er <= m_last.
  logic [31:0] m_mem [D];
  int m_src, m_dst, m_len, m_e0, m_last, m_kind, m_L;

  function automatic bit model_busy(input int er);
    return (er > m_e0) && (er <= m_last);
  endfunction

  function automatic int model_rem(input int er);
    int k;
    if (!model_busy(er)) return 0;
    k = er - m_e0;
    if (m_kind == 0) return m_L - (k - 1) / 2;  // copy: one word per two cycles
    return m_L - (k - 1);                       // fill: one word per cycle
  endfunction

  function automatic bit model_bad(input logic [31:0] va);
    bit b;
    b = (va[31:13] != 19'd0) || (int'(va[9:0]) >= D);
`ifndef RAM_DMA_CI_FILL_EN
    if (va[12:10] == 3'd6) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input bit bad, input int er);
    if (bad || op == 3'd0 || op == 3'd7 || !model_busy(er)) return 0;
    return m_last + 1 - er;
  endfunction

  task automatic model_exec(input logic [2:0] op, input int addr, input logic [31:0] vb,
                            input int ex, output logic [31:0] r);
    int v;
    r = '0;
    case (op)
      3'd0: r = m_mem[addr];
      3'd1: m_mem[addr] = vb;
      3'd2: m_src = int'(vb % 32'(D));
      3'd3: m_dst = int'(vb % 32'(D));
      3'd4: begin
        v = int'(vb % 32'(2 * D));
        m_len = (v > D) ? D : v;
      end
      3'd5: if (m_len > 0) begin
        for (int i = 0; i < m_len; i++) m_mem[(m_dst + i) % D] = m_mem[(m_src + i) % D];
        m_e0 = ex; m_last = ex + 2 * m_len; m_kind = 0; m_L = m_len;
      end
      3'd6: if (m_len > 0) begin
        for (int i = 0; i < m_len; i++) m_mem[(m_dst + i) % D] = vb;
        m_e0 = ex; m_last = ex + m_len; m_kind = 1; m_L = m_len;
      end
      default: begin
        r = 32'(model_rem(ex));
        if (model_busy(ex)) r[31] = 1'b1;
      end
    endcase
  endtask

  task automatic model_reset();
    m_src = 0; m_dst = 0; m_len = 0; m_e0 = -1; m_last = -1; m_kind = 0; m_L = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Issue one request; lat counts edges after the request edge until done
  // (0 means done in the very next cycle), -1 when the bound expires.
  task automatic send(input logic [31:0] va, input logic [31:0] vb,
                      output logic [31:0] res, output int lat);
    ciN = CID; valueA = va; valueB = vb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 3000) begin
      if (result !== 32'd0) zero_bad = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
    res = result;
    if (!done) lat = -1;
  endtask

  task automatic do_raw(input string name, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] res);
    bit bad;
    int er, lat_e, lat;
    logic [31:0] exp_r;
    bad   = model_bad(va);
    er    = cyc + 1;
    lat_e = model_lat(va[12:10], bad, er);
    exp_r = '0;
    if (!bad) model_exec(va[12:10], int'(va[AB-1:0]), vb, er + lat_e, exp_r);
    send(va, vb, res, lat);
    chk({name, "_lat"}, 32'(lat), 32'(lat_e));
    chk({name, "_res"}, res, exp_r);
  endtask

  task automatic do_cmd(input string name, input int op, input int addr,
                        input logic [31:0] vb, output logic [31:0] res);
    do_raw(name, (32'(op) << 10) | 32'(addr), vb, res);
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target - 1) begin
      @(posedge clock); #1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_res;
  } vec_t;

  vec_t tbl [10];

  // ---------------- main test ----------------
  initial begin
    logic [31:0] r, junk;
    int lat, e0, seen, sel;

    tbl[0] = '{"wr3",         32'h0000_0403, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{"rd3",         32'h0000_0003, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{"wr511",       32'h0000_05FF, 32'h1234_5678, 32'h0};
    tbl[3] = '{"rd511",       32'h0000_01FF, 32'h0,         32'h1234_5678};
    tbl[4] = '{"bad_hi",      32'h0010_0000, 32'hFFFF_FFFF, 32'h0};
    tbl[5] = '{"bad_addr",    32'h0000_0603, 32'h0000_0BAD, 32'h0};
    tbl[6] = '{"rd3_again",   32'h0000_0003, 32'h0,         32'hDEAD_BEEF};
    tbl[7] = '{"bad_bit13",   32'h0000_2403, 32'h0000_0BAD, 32'h0};
    tbl[8] = '{"status_idle", 32'h0000_1C00, 32'h0,         32'h0};
    tbl[9] = '{"rd511_again", 32'h0000_01FF, 32'h0,         32'h1234_5678};

    model_reset();
    reset = 1'b1; start = 1'b0; ciN = CID; valueA = '0; valueB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    do_cmd("status_after_reset", 7, 0, 32'd0, r);

    // fill the whole RAM with random words so every later read is defined
    for (int i = 0; i < D; i++) begin
      m_mem[i] = $urandom();
      send((32'd1 << 10) | 32'(i), m_mem[i], junk, lat);
    end

    // table-driven single-cycle commands on an idle engine
    for (int i = 0; i < 10; i++) begin
      bit bad;
      bad = model_bad(tbl[i].va);
      if (!bad) model_exec(tbl[i].va[12:10], int'(tbl[i].va[AB-1:0]), tbl[i].vb, cyc + 1, junk);
      send(tbl[i].va, tbl[i].vb, r, lat);
      chk({tbl[i].name, "_lat"}, 32'(lat), 32'd0);
      chk({tbl[i].name, "_res"}, r, tbl[i].exp_res);
    end
    @(posedge clock); #1;
    chk("done_is_pulse", {31'd0, done}, 32'd0);
    chk("result_zero_idle", result, 32'd0);

    // basic 8-word copy 0..7 -> 16..23 and busy timing
    for (int i = 0; i < 8; i++) do_cmd("init_src", 1, i, 32'h11 * i, r);
    do_cmd("set_src", 2, 0, 32'd0, r);
    do_cmd("set_dst", 3, 0, 32'd16, r);
    do_cmd("set_len", 4, 0, 32'd8, r);
    do_cmd("copy8", 5, 0, 32'd0, r);
    e0 = cyc;
    do_cmd("status_busy", 7, 0, 32'd0, r);
    chk("status_busy_const", r, 32'h8000_0008);
    wait_edge(e0 + 16);
    do_cmd("status_last_busy", 7, 0, 32'd0, r);
    do_cmd("status_cleared", 7, 0, 32'd0, r);
    chk("status_cleared_const", r, 32'h0);
    for (int i = 0; i < 8; i++) do_cmd("copied", 0, 16 + i, 32'd0, r);

    // read served mid-copy, write held pending until the engine stops
    do_cmd("set_dst32", 3, 0, 32'd32, r);
    do_cmd("copy8b", 5, 0, 32'd0, r);
    e0 = cyc;
    do_cmd("read_mid_copy", 0, 5, 32'd0, r);
    do_cmd("write_pending", 1, 32, 32'hCAFE_F00D, r);
    chk("write_pending_edge", 32'(cyc), 32'(e0 + 17));
    do_cmd("read_after_pending", 0, 32, 32'd0, r);
    do_cmd("read_copied33", 0, 33, 32'd0, r);

    // copy wrapping at the top of memory
    do_cmd("set_src510", 2, 0, 32'd510, r);
    do_cmd("set_dst2", 3, 0, 32'd2, r);
    do_cmd("set_len4", 4, 0, 32'd4, r);
    do_cmd("copy_wrap", 5, 0, 32'd0, r);
    wait_edge(m_last + 1);
    for (int i = 0; i < 4; i++) do_cmd("wrap_dst", 0, 2 + i, 32'd0, r);

    // zero-length copy finishes at once and never goes busy
    do_cmd("set_len0", 4, 0, 32'd0, r);
    do_cmd("copy_len0", 5, 0, 32'd0, r);
    do_cmd("status_len0", 7, 0, 32'd0, r);

    // request with a foreign ciN is ignored
    ciN = CID ^ 8'hFF; valueA = (32'd1 << 10) | 32'd3; valueB = 32'h0BAD_0BAD; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; ciN = CID;
    seen = 0;
    repeat (4) begin
      if (done) seen = 1;
      @(posedge clock); #1;
    end
    chk("wrong_cin_no_done", 32'(seen), 32'd0);
    do_cmd("wrong_cin_mem", 0, 3, 32'd0, r);

    // randomized command mix against the model
    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: do_cmd("rnd_write", 1, $urandom_range(0, D - 1), $urandom(), r);
        2: begin
          if (model_busy(cyc + 1)) do_cmd("rnd_status", 7, 0, 32'd0, r);
          else do_cmd("rnd_read", 0, $urandom_range(0, D - 1), 32'd0, r);
        end
        3: do_cmd("rnd_src", 2, 0, $urandom(), r);
        4: do_cmd("rnd_dst", 3, 0, $urandom(), r);
        5: begin
          if ($urandom_range(0, 7) == 0) do_cmd("rnd_len_big", 4, 0, $urandom(), r);
          else do_cmd("rnd_len", 4, 0, 32'($urandom_range(0, 20)), r);
        end
        6: do_cmd("rnd_copy", 5, 0, 32'd0, r);
        7: do_cmd("rnd_status", 7, 0, 32'd0, r);
        8: do_raw("rnd_bad", $urandom() | 32'h0000_2000, $urandom(), r);
        default: repeat ($urandom_range(0, 5)) begin
          @(posedge clock); #1;
        end
      endcase
    end
    wait_edge(m_last + 2);
    for (int i = 0; i < 16; i++) do_cmd("rnd_sweep", 0, $urandom_range(0, D - 1), 32'd0, r);

    // fill option
    do_cmd("set_dst100", 3, 0, 32'd100, r);
    do_cmd("set_len5", 4, 0, 32'd5, r);
    do_cmd("fill", 6, 0, 32'hA5A5_A5A5, r);
    e0 = cyc;
`ifdef RAM_DMA_CI_FILL_EN
    wait_edge(e0 + 5);
    do_cmd("fill_status_busy", 7, 0, 32'd0, r);
    chk("fill_status_busy_const", r, 32'h8000_0001);
    do_cmd("fill_status_done", 7, 0, 32'd0, r);
    for (int i = 0; i < 5; i++) begin
      do_cmd("filled", 0, 100 + i, 32'd0, r);
      chk("filled_const", r, 32'hA5A5_A5A5);
    end
`else
    chk("fill_disabled_res", r, 32'd0);
    do_cmd("fill_disabled_status", 7, 0, 32'd0, r);
    for (int i = 0; i < 5; i++) do_cmd("fill_untouched", 0, 100 + i, 32'd0, r);
`endif

    // reset in the middle of a copy
    do_cmd("rst_src", 2, 0, 32'd0, r);
    do_cmd("rst_dst", 3, 0, 32'd64, r);
    do_cmd("rst_len", 4, 0, 32'd20, r);
    do_cmd("rst_copy", 5, 0, 32'd0, r);
    repeat (5) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    chk("midcopy_reset_done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    @(posedge clock); #1;
    do_cmd("status_after_abort", 7, 0, 32'd0, r);
    chk("status_after_abort_const", r, 32'd0);
    do_cmd("copy_after_abort", 5, 0, 32'd0, r);
    do_cmd("status_len_cleared", 7, 0, 32'd0, r);
    do_cmd("ram_kept", 0, 7, 32'd0, r);

    chk("result_zero_while_waiting", {31'd0, zero_bad}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_dma_ci_engine.md
Name: ram_dma_ci_engine

Overview:
- Custom-instruction scratchpad RAM with a built-in block-move engine; a parametrised successor of the single-port CI RAM.
- The CPU reads and writes words through the CI path on port A.
- An internal engine copies (and optionally fills) address ranges through port B while the CPU keeps issuing reads.
- Sits on the CPU custom-instruction bus next to the other CI modules.

Parameters:
- customId, 8'h00, ciN value this block answers to.
- addrBits, 9, word-address width; depth = 2^addrBits words; legal range 4..10.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle CI request pulse.
- ciN  input  8  CI number; the request is active only when ciN == customId.
- valueA  input  32  command word: [12:10] opcode, [addrBits-1:0] address.
- valueB  input  32  write data / operand.
- done  output  1  one-cycle completion pulse.
- result  output  32  read/status data; valid only while done=1, else 0.

Behaviour:
- Clock is `clock`; reset is `reset`, asynchronous and active-high.
- Reset values: done=0, result=0, busy=0, src=dst=len=0, engine IDLE, pending op cleared. A reset mid-transfer aborts it; RAM contents are not cleared.
- Request: start=1 and ciN==customId. The block latches opcode, address and valueB on that edge. No new request may arrive before done.
- Invalid command: valueA[31:13]!=0 or valueA[9:addrBits]!=0. Response is done at T+1 with result=0, no state change.
- Opcode 0 READ: result=mem[addr], done at T+1. Allowed while busy; served from port A.
- Opcode 1 WRITE: mem[addr]<=valueB, done at T+1.
- Opcode 2 SET_SRC: src<=valueB[addrBits-1:0].
- Opcode 3 SET_DST: dst<=valueB[addrBits-1:0].
- Opcode 4 SET_LEN: len<=valueB[addrBits:0], saturated to depth.
- Opcode 5 START_COPY: starts a copy of len words from src to dst.
- Opcode 6 START_FILL: requires FILL_EN; otherwise treated as invalid.
- Opcode 7 STATUS: result={busy,(30-addrBits) zeros,remaining[addrBits:0]}, done at T+1. Allowed while busy.
- Opcodes 1-6 while busy=1:
  - The op is held pending and done stays low.
  - It executes in the first cycle busy==0; done follows one cycle later.
  - Port A and port B therefore never write in the same cycle.
- Engine FSM states: IDLE, RD, WR, FILL.
- IDLE -> RD on START_COPY with len>0. busy=1 from T+1. remaining=len, rp=src, wp=dst.
- len==0 on START_COPY/START_FILL: done at T+1, busy stays 0.
- RD: port B reads mem[rp]; go to WR.
- WR: port B writes mem[wp] <= read data; rp++, wp++, remaining--. Go to RD if remaining>1, else IDLE.
- Copy throughput: 2 cycles per word. busy clears at T+1+2*len.
- Pointers wrap modulo depth.
- Overlap rule: ascending forward copy, word i is read before word i is written. With dst>src overlapping, data replicates; this is the defined result.
- SET_* registers are not modified by the engine; they keep their programmed values after a transfer.

Optional Feature:
- Macro: RAM_DMA_CI_FILL_EN.
- Defined: opcode 6 START_FILL latches valueB as the pattern. The FSM goes IDLE -> FILL and writes the pattern to mem[wp] once per cycle for len words. busy clears at T+1+len. STATUS reports it like a copy.
- Undefined: opcode 6 gives done at T+1 with result=0 and no state change. The FILL state is not synthesised.

Test Plan:
- WRITE addr 3 value 0xDEADBEEF, then READ addr 3 -> each done at T+1; read result=0xDEADBEEF; result=0 when done=0.
- mem[0..7]=0x11*i; SET_SRC 0, SET_DST 16, SET_LEN 8, START_COPY -> STATUS gives 0x80000008; busy=0 exactly 16 cycles after START's done; mem[16..23]=0x00..0x77.
- WRITE issued at busy cycle 2 of an 8-word copy -> done withheld until busy falls, then pulses next cycle; a READ mid-copy returns at T+1.
- SET_SRC 510, SET_DST 2, SET_LEN 4 (addrBits=9), START_COPY -> mem[2..5]=old mem[510],mem[511],mem[0],mem[1].
- valueA=0x00100000 -> done at T+1, result 0, no memory change; ciN!=customId -> no done; reset mid-copy -> busy=0, STATUS=0.
- With RAM_DMA_CI_FILL_EN: SET_DST 100, SET_LEN 5, START_FILL valueB=0xA5A5A5A5 -> mem[100..104]=0xA5A5A5A5, busy clears 5 cycles after done. Without the macro: opcode 6 -> result 0, no memory change.
